intersection_scheduler: RTL and testbench
=========================================

Name: intersection_scheduler

Overview:
- Cycle-level controller for a two-road intersection: main road (lights R1/Y1/G1), side road (lights R2/Y2/G2) and a pedestrian crossing (walk).
- Shares the single "green right-of-way" resource between the side-road car sensor and the pedestrian push-button using round-robin arbitration.
- Guarantees a main-road minimum green between services.
- Sits above the per-road light blocks; all timing is in seconds via an external 1-second tick enable.

Parameters:
- CNT_W, 4, width of the internal seconds timer.
- MAIN_MIN, 4, main-road minimum green in ticks (1..2^CNT_W-1).
- SIDE_GRN, 4, side-road green in ticks (>=1).
- YEL, 2, yellow duration for either road in ticks (>=1).
- ALL_RED, 1, all-red clearance in ticks (>=1).
- WALK, 3, pedestrian walk duration in ticks (>=1).

Ports:
- clk, input, 1, system clock (rising edge).
- reset, input, 1, asynchronous, active-high reset.
- tick, input, 1, one-cycle 1-second enable pulse, synchronous to clk.
- car_sensor, input, 1, side-road car present (level or pulse).
- ped_request, input, 1, pedestrian button (level or pulse).
- R1, Y1, G1, output, 1 each, main-road lights (registered).
- R2, Y2, G2, output, 1 each, side-road lights (registered).
- walk, output, 1, pedestrian walk lamp (registered).
- present_state, output, 3, current state encoding (registered).

Behaviour:
- States and encodings: MG=0 (main green), MY=1 (main yellow), AR1=2 (all red), SG=3 (side green), SY=4 (side yellow), PW=5 (ped walk), AR2=6 (all red).
- Codes 7 and any illegal code go to MG on the next edge.
- Reset (asynchronous, takes effect immediately, including mid-sequence):
  - present_state=MG, timer=0, car_pend=0, ped_pend=0, last=PED (so the car is served first on a tie).
  - Outputs: G1=1, R2=1, all other lights 0, walk=0.
- Timer:
  - Increments only on tick=1 and clears to 0 on every state change.
  - A timed state of duration D exits on the edge where tick=1 and timer==D-1, so it lasts exactly D ticks.
  - In MG the timer saturates at MAIN_MIN-1.
- Request latches:
  - car_pend is set by car_sensor=1 on any edge and cleared on the edge that enters SG.
  - ped_pend is set by ped_request=1 and cleared on the edge that enters PW.
  - An input asserted on the clearing edge of its own latch does not re-set it; a request must be re-asserted after service begins.
  - Effective request on a given edge: carq = car_pend | car_sensor, pedq = ped_pend | ped_request.
- Transitions (all evaluated on tick edges only):
  - MG -> MY when timer==MAIN_MIN-1 and (carq | pedq). Otherwise stay in MG indefinitely.
  - MY -> AR1 after YEL.
  - AR1 -> after ALL_RED:
    - both carq and pedq: SG if last==PED, else PW.
    - only carq: SG.
    - only pedq: PW.
    - neither: MG.
  - SG -> SY after SIDE_GRN; sets last=CAR on entry to SG.
  - SY -> AR2 after YEL.
  - PW -> AR2 after WALK; sets last=PED on entry to PW.
  - AR2 -> MG after ALL_RED. Main-road minimum green always runs between two services.
- Output decode: registered from next state, so lights change on the same edge as present_state (no extra cycle of latency).
  - MG: G1, R2.
  - MY: Y1, R2.
  - AR1, AR2: R1, R2.
  - SG: R1, G2.
  - SY: R1, Y2.
  - PW: R1, R2, walk.
- Invariants:
  - Exactly one of R1/Y1/G1 and exactly one of R2/Y2/G2 is high at all times.
  - G1 and G2 are never both high.
  - walk=1 only when R1=R2=1.
- Simultaneous events: tick together with a new request in MG at the minimum-green boundary is treated as a pending request, and the exit happens on that edge.

Test Plan:
- Reset, no requests, 20 ticks -> present_state stays 0, G1=R2=1, walk=0; assert reset mid-SG -> next sample shows state 0, G1=1.
- car_sensor pulsed 1 cycle at tick 1 -> MY entered on tick 4 edge; then AR1 for 1 tick, SG for 4 ticks, SY for 2, AR2 for 1, then MG; car_pend=0 after SG entry.
- ped_request only -> MG(4) -> MY(2) -> AR1(1) -> PW(3, walk=1, R1=R2=1) -> AR2(1) -> MG.
- car_sensor and ped_request both held from reset -> first service is SG, next service is PW, then SG again (round-robin alternation over 3 cycles).
- car_sensor asserted at tick 9 (MG already saturated) -> MY entered on the next tick edge, not the next clock.
- Random tick/request stimulus for 10^4 cycles -> light-exclusion and walk invariants never violated; every state dwell equals its parameter in ticks.

Source files
------------

// File: rtl/intersection_scheduler.sv
// Two-road intersection controller: round-robin sharing of the right-of-way between the
// side-road car sensor and the pedestrian button, with a guaranteed main-road minimum green.
module intersection_scheduler #(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned MAIN_MIN = 4,
  parameter int unsigned SIDE_GRN = 4,
  parameter int unsigned YEL      = 2,
  parameter int unsigned ALL_RED  = 1,
  parameter int unsigned WALK     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       car_sensor,
  input  logic       ped_request,
  output logic       R1,
  output logic       Y1,
  output logic       G1,
  output logic       R2,
  output logic       Y2,
  output logic       G2,
  output logic       walk,
  output logic [2:0] present_state
);

  localparam logic [2:0] MG  = 3'd0;
  localparam logic [2:0] MY  = 3'd1;
  localparam logic [2:0] AR1 = 3'd2;
  localparam logic [2:0] SG  = 3'd3;
  localparam logic [2:0] SY  = 3'd4;
  localparam logic [2:0] PW  = 3'd5;
  localparam logic [2:0] AR2 = 3'd6;

  localparam logic LAST_CAR = 1'b0;
  localparam logic LAST_PED = 1'b1;

  // Timer value on the final tick of each timed state
  localparam logic [CNT_W-1:0] MAIN_END = CNT_W'(MAIN_MIN - 1);
  localparam logic [CNT_W-1:0] SIDE_END = CNT_W'(SIDE_GRN - 1);
  localparam logic [CNT_W-1:0] YEL_END  = CNT_W'(YEL - 1);
  localparam logic [CNT_W-1:0] AR_END   = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] WALK_END = CNT_W'(WALK - 1);

  // Lamp vector order: {R1, Y1, G1, R2, Y2, G2, walk}
  localparam logic [6:0] LAMPS_RESET = 7'b0011000;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             car_pend_q, car_pend_d;
  logic             ped_pend_q, ped_pend_d;
  logic             last_q, last_d;
  logic [6:0]       lamps_q, lamps_d;
  logic             carq, pedq, enter_sg, enter_pw;

  always_comb begin
    carq    = car_pend_q | car_sensor;
    pedq    = ped_pend_q | ped_request;
    state_d = state_q;
    case (state_q)
      MG:  if (tick && timer_q == MAIN_END && (carq || pedq)) state_d = MY;
      MY:  if (tick && timer_q == YEL_END) state_d = AR1;
      AR1: begin
        if (tick && timer_q == AR_END) begin
          // On a tie the car wins only if the pedestrian was served last
          if (carq && (!pedq || last_q == LAST_PED)) state_d = SG;
          else if (pedq)                             state_d = PW;
          else                                       state_d = MG;
        end
      end
      SG:  if (tick && timer_q == SIDE_END) state_d = SY;
      SY:  if (tick && timer_q == YEL_END) state_d = AR2;
      PW:  if (tick && timer_q == WALK_END) state_d = AR2;
      AR2: if (tick && timer_q == AR_END) state_d = MG;
      default: state_d = MG;
    endcase
  end

  always_comb begin
    enter_sg = (state_d == SG) && (state_q != SG);
    enter_pw = (state_d == PW) && (state_q != PW);

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (tick && !(state_q == MG && timer_q == MAIN_END)) begin
      timer_d = timer_q + CNT_W'(1);
    end else begin
      timer_d = timer_q;
    end

    car_pend_d = enter_sg ? 1'b0 : (car_pend_q | car_sensor);
    ped_pend_d = enter_pw ? 1'b0 : (ped_pend_q | ped_request);

    if (enter_sg)      last_d = LAST_CAR;
    else if (enter_pw) last_d = LAST_PED;
    else               last_d = last_q;
  end

  // Lamps decode from the next state so they switch on the same edge as present_state
  always_comb begin
    case (state_d)
      MG:       lamps_d = 7'b0011000;
      MY:       lamps_d = 7'b0101000;
      AR1, AR2: lamps_d = 7'b1001000;
      SG:       lamps_d = 7'b1000010;
      SY:       lamps_d = 7'b1000100;
      PW:       lamps_d = 7'b1001001;
      default:  lamps_d = LAMPS_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= MG;
      timer_q    <= '0;
      car_pend_q <= 1'b0;
      ped_pend_q <= 1'b0;
      last_q     <= LAST_PED;
      lamps_q    <= LAMPS_RESET;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      car_pend_q <= car_pend_d;
      ped_pend_q <= ped_pend_d;
      last_q     <= last_d;
      lamps_q    <= lamps_d;
    end
  end

  assign {R1, Y1, G1, R2, Y2, G2, walk} = lamps_q;
  assign present_state = state_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Scoreboard bench for intersection_scheduler: expected state entries (state, tick number) are
// queued by the stimulus and popped by a monitor whenever present_state changes.
module tb_intersection_scheduler;

  localparam logic [2:0] MG  = 3'd0;
  localparam logic [2:0] MY  = 3'd1;
  localparam logic [2:0] AR1 = 3'd2;
  localparam logic [2:0] SG  = 3'd3;
  localparam logic [2:0] SY  = 3'd4;
  localparam logic [2:0] PW  = 3'd5;
  localparam logic [2:0] AR2 = 3'd6;

  localparam int MAIN_MIN = 4;
  localparam int SIDE_GRN = 4;
  localparam int YEL      = 2;
  localparam int ALL_RED  = 1;
  localparam int WALK     = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       car_sensor = 1'b0;
  logic       ped_request = 1'b0;
  logic       R1, Y1, G1, R2, Y2, G2, walk;
  logic [2:0] present_state;

  int n_cmp = 0;
  int n_err = 0;
  int tick_cnt = 0;
  int entry_tick = 0;
  bit rand_mode = 1'b0;
  logic [2:0] prev_state = 3'd0;

  typedef struct {
    logic [2:0] st;
    int         tk;
  } tr_t;
  tr_t exp_q[$];

  intersection_scheduler #(
    .CNT_W   (4),
    .MAIN_MIN(MAIN_MIN),
    .SIDE_GRN(SIDE_GRN),
    .YEL     (YEL),
    .ALL_RED (ALL_RED),
    .WALK    (WALK)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .car_sensor   (car_sensor),
    .ped_request  (ped_request),
    .R1           (R1),
    .Y1           (Y1),
    .G1           (G1),
    .R2           (R2),
    .Y2           (Y2),
    .G2           (G2),
    .walk         (walk),
    .present_state(present_state)
  );

  always #5 clk = ~clk;

  // Number of tick edges seen since reset was released
  always @(posedge clk or posedge reset) begin
    if (reset)     tick_cnt <= 0;
    else if (tick) tick_cnt <= tick_cnt + 1;
  end

  function automatic logic [6:0] exp_lamps(input logic [2:0] s);
    case (s)
      MG:       return 7'b0011000;
      MY:       return 7'b0101000;
      AR1, AR2: return 7'b1001000;
      SG:       return 7'b1000010;
      SY:       return 7'b1000100;
      PW:       return 7'b1001001;
      default:  return 7'b0000000;
    endcase
  endfunction

  function automatic int dwell_of(input logic [2:0] s);
    case (s)
      MY, SY:   return YEL;
      AR1, AR2: return ALL_RED;
      SG:       return SIDE_GRN;
      PW:       return WALK;
      default:  return MAIN_MIN;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_tr(input logic [2:0] s, input int t);
    tr_t e;
    e.st = s;
    e.tk = t;
    exp_q.push_back(e);
  endtask

  // Monitor: lamp decode every cycle, scoreboard or dwell check on every state change
  always @(negedge clk) begin
    if (reset) begin
      prev_state = MG;
      entry_tick = 0;
    end else begin
      check("lamps", int'({R1, Y1, G1, R2, Y2, G2, walk}), int'(exp_lamps(present_state)));
      if (walk) check("walk_all_red", int'({R1, R2}), 3);
      if (present_state != prev_state) begin
        if (rand_mode) begin
          if (prev_state == MG)
            check("mg_min_dwell", int'(tick_cnt - entry_tick >= MAIN_MIN), 1);
          else
            check("dwell", tick_cnt - entry_tick, dwell_of(prev_state));
        end else if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_transition: got state %0d at tick %0d, required none",
                   present_state, tick_cnt);
        end else begin
          tr_t e;
          e = exp_q.pop_front();
          check("state", int'(present_state), int'(e.st));
          check("tick_no", tick_cnt, e.tk);
        end
        prev_state = present_state;
        entry_tick = tick_cnt;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_edge();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      step();
      step();
      tick_edge();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic push_car_service(input int t0);
    expect_tr(MY, t0);
    expect_tr(AR1, t0 + 2);
    expect_tr(SG, t0 + 3);
    expect_tr(SY, t0 + 7);
    expect_tr(AR2, t0 + 9);
    expect_tr(MG, t0 + 10);
  endtask

  initial begin
    // Idle: no requests, main green forever
    do_reset();
    ticks(20);
    check("idle_state", int'(present_state), 0);
    check("idle_g1", int'(G1), 1);
    check("idle_r2", int'(R2), 1);
    check("idle_walk", int'(walk), 0);

    // Car pulse between tick 1 and tick 2
    do_reset();
    push_car_service(4);
    ticks(1);
    car_sensor = 1'b1;
    step();
    car_sensor = 1'b0;
    ticks(29);
    check("car_drained", exp_q.size(), 0);

    // Pedestrian pulse only
    do_reset();
    expect_tr(MY, 4);
    expect_tr(AR1, 6);
    expect_tr(PW, 7);
    expect_tr(AR2, 10);
    expect_tr(MG, 11);
    ticks(1);
    ped_request = 1'b1;
    step();
    ped_request = 1'b0;
    ticks(19);
    check("ped_drained", exp_q.size(), 0);

    // Car arrives on tick 9 with main green already saturated
    do_reset();
    push_car_service(9);
    ticks(8);
    step();
    step();
    car_sensor = 1'b1;
    tick_edge();
    car_sensor = 1'b0;
    ticks(16);
    check("sat_drained", exp_q.size(), 0);

    // Both held from reset: SG, PW, SG alternation, then reset in the middle of SG
    car_sensor = 1'b1;
    ped_request = 1'b1;
    do_reset();
    push_car_service(4);
    expect_tr(MY, 18);
    expect_tr(AR1, 20);
    expect_tr(PW, 21);
    expect_tr(AR2, 24);
    expect_tr(MG, 25);
    expect_tr(MY, 29);
    expect_tr(AR1, 31);
    expect_tr(SG, 32);
    ticks(33);
    check("rr_drained", exp_q.size(), 0);
    check("rr_in_sg", int'(present_state), int'(SG));
    reset = 1'b1;
    #2;
    check("async_rst_state", int'(present_state), 0);
    check("async_rst_g1", int'(G1), 1);
    check("async_rst_r2", int'(R2), 1);
    check("async_rst_g2", int'(G2), 0);
    car_sensor = 1'b0;
    ped_request = 1'b0;

    // Random tick/request traffic: lamp decode and dwell times checked by the monitor
    do_reset();
    rand_mode = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      tick        = ($urandom_range(0, 3) == 0);
      car_sensor  = ($urandom_range(0, 15) == 0);
      ped_request = ($urandom_range(0, 15) == 0);
      step();
    end
    tick = 1'b0;
    car_sensor = 1'b0;
    ped_request = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
